// File: rtl/control_ventana_eventos_pkg.sv
// Shared constants for the event-window controller: state encoding, defaults
// and the timer width helper. The RTL and the bench both import this package.
package control_ventana_eventos_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CLEAR   = 2'd1;
    localparam logic [1:0] ST_COUNT   = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    localparam int N_DEFAULT   = 3;
    localparam int WIN_DEFAULT = 100;

    // Timer must hold WIN-1; never narrower than one bit.
    function automatic int timer_width(input int win);
        return (win > 1) ? $clog2(win) : 1;
    endfunction

endpackage

// File: rtl/control_ventana_eventos_temporizador_ventana.sv
// Window down-counter: loads WIN-1, decrements while enabled, flags zero.
module temporizador_ventana
    import control_ventana_eventos_pkg::*;
#(
    parameter int WIN = WIN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int TW = timer_width(WIN);
    localparam logic [TW-1:0] LOAD_VAL = TW'(WIN - 1);

    logic [TW-1:0] timer_q, timer_d;

    // Saturates at zero so a stray decrement never wraps the window.
    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = LOAD_VAL;
        end else if (dec && (timer_q != '0)) begin
            timer_d = timer_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign zero = (timer_q == '0);

endmodule

// File: rtl/control_ventana_eventos.sv
// Controller that opens a WIN-cycle counting window on the event counter and
// latches the count and overflow flag at its end, optionally back to back.
module control_ventana_eventos
    import control_ventana_eventos_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int WIN = WIN_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         cont,
    input  logic         tic,
    input  logic [N-1:0] data_in,
    input  logic         ov_in,
    output logic         cnt,
    output logic         cnt_rst,
    output logic         ff_rst,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         ov_result
);

    logic [1:0]   state_q, state_d;
    logic         done_q, done_d;
    logic [N-1:0] result_q, result_d;
    logic         ov_q, ov_d;
    logic         tmr_zero;

    temporizador_ventana #(
        .WIN (WIN)
    ) u_temporizador (
        .clk  (clk),
        .rst  (rst),
        .load (state_q == ST_CLEAR),
        .dec  (state_q == ST_COUNT),
        .zero (tmr_zero)
    );

    // Abort outranks every other transition; a capture is skipped when aborted.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        result_d = result_q;
        ov_d     = ov_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = abort ? ST_IDLE : ST_COUNT;
            end
            ST_COUNT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = data_in;
                    ov_d     = ov_in;
                    done_d   = 1'b1;
                    state_d  = cont ? ST_CLEAR : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            ov_q     <= ov_d;
        end
    end

    assign cnt       = (state_q == ST_COUNT) && tic;
    assign cnt_rst   = (state_q == ST_CLEAR);
    assign ff_rst    = (state_q == ST_CLEAR);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign ov_result = ov_q;

endmodule

// File: tb/tb_control_ventana_eventos.sv
// Bench for control_ventana_eventos with N=3, WIN=8 and a behavioural
// modulo-8 counter plus overflow latch standing in for the datapath.
module tb_control_ventana_eventos;
    import control_ventana_eventos_pkg::*;

    localparam int N   = N_DEFAULT;
    localparam int WIN = 8;

    logic         clk = 1'b0;
    logic         rst, start, abort, cont, tic;
    logic [N-1:0] data_in;
    logic         ov_in;
    logic         cnt, cnt_rst, ff_rst, busy, done, ov_result;
    logic [N-1:0] result;

    control_ventana_eventos #(
        .N   (N),
        .WIN (WIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cont      (cont),
        .tic       (tic),
        .data_in   (data_in),
        .ov_in     (ov_in),
        .cnt       (cnt),
        .cnt_rst   (cnt_rst),
        .ff_rst    (ff_rst),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ov_result (ov_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: event counter and overflow SR flip-flop.
    logic [N-1:0] ctr_q = '0;
    logic         sr_q  = 1'b0;
    always @(posedge clk) begin
        if (cnt_rst === 1'b1)  ctr_q <= '0;
        else if (cnt === 1'b1) ctr_q <= ctr_q + 1'b1;
        if (ff_rst === 1'b1)                      sr_q <= 1'b0;
        else if (cnt === 1'b1 && ctr_q == '1)     sr_q <= 1'b1;
    end
    assign data_in = ctr_q;
    assign ov_in   = sr_q;

    typedef struct {
        logic [N-1:0] res;
        logic         ov;
        int           done_cyc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int           ntics;
        logic [N-1:0] res;
        logic         ov;
    } vec_t;
    vec_t vecs[6];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every done pulse must match the oldest expected capture, on its cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_result", result, e.res);
                chk("done_ov", ov_result, e.ov);
                chk("done_cycle", cyc, e.done_cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input int ntics, input bit do_start, input bit cont_v,
                              input int abort_at, input logic [N-1:0] eres, input logic eov);
        int c_clr;
        if (do_start) begin
            start = 1'b1;
            step();
        end
        c_clr = cyc;
        tic   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("clear_cnt_rst", cnt_rst, 1);
        chk("clear_ff_rst", ff_rst, 1);
        chk("clear_cnt", cnt, 0);
        chk("clear_busy", busy, 1);
        step();
        for (int i = 0; i < WIN; i++) begin
            start = 1'b0;
            tic   = (i < ntics);
            abort = (i == abort_at);
            @(negedge clk);
            chk("count_cnt", cnt, tic);
            chk("count_busy", busy, 1);
            step();
            if (i == abort_at) begin
                abort = 1'b0;
                tic   = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                return;
            end
        end
        tic   = 1'b1;
        start = 1'b1;
        cont  = cont_v;
        sbq.push_back('{eres, eov, c_clr + WIN + 2});
        @(negedge clk);
        chk("capture_cnt", cnt, 0);
        chk("capture_busy", busy, 1);
        step();
        tic   = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        if (!cont_v) begin
            @(negedge clk);
            chk("after_capture_busy", busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{5, 3'd5, 1'b0};
        vecs[1] = '{8, 3'd0, 1'b1};
        vecs[2] = '{2, 3'd2, 1'b0};
        vecs[3] = '{0, 3'd0, 1'b0};
        vecs[4] = '{7, 3'd7, 1'b0};
        vecs[5] = '{3, 3'd3, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0; tic = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_cnt_rst", cnt_rst, 0);
        chk("rst_ff_rst", ff_rst, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_ov", ov_result, 0);
        rst = 1'b0;
        tic = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            run_window(vecs[v].ntics, 1'b1, 1'b0, -1, vecs[v].res, vecs[v].ov);
            step();
        end

        // Abort on the 4th COUNT cycle after a result of 5.
        run_window(5, 1'b1, 1'b0, -1, 3'd5, 1'b0);
        step();
        run_window(6, 1'b1, 1'b0, 3, 3'd0, 1'b0);
        repeat (12) step();
        chk("abort_result_held", result, 5);
        chk("abort_ov_held", ov_result, 0);

        // Continuous mode: two back-to-back windows.
        run_window(3, 1'b1, 1'b1, -1, 3'd3, 1'b0);
        run_window(6, 1'b0, 1'b0, -1, 3'd6, 1'b0);
        step();

        // Reset in the middle of a window.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        tic = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", cnt, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_ov", ov_result, 0);
        step();
        rst = 1'b0;
        tic = 1'b0;
        step();
        @(negedge clk);
        chk("postrst_busy", busy, 0);
        step();
        run_window(4, 1'b1, 1'b0, -1, 3'd4, 1'b0);
        repeat (4) step();
        chk("pending_done", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
